// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC/fetch sequencer and its branch-trace buffer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } seqState_t;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] tgt;
    } trcEntry_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP              = 32'd4;

    // Redirect targets are always word aligned.
    function automatic logic [31:0] alignWord(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/branch_trace_fifo.sv
// Circular buffer of taken-branch records; a push while full overwrites the oldest entry.
// Read side always presents the oldest entry (zero when empty).
module branch_trace_fifo
    import pc_seq_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      CLK,
    input  logic      RESETn,
    input  logic      push,
    input  trcEntry_t pushData,
    input  logic      pop,
    output trcEntry_t rdData,
    output logic      empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    trcEntry_t       memReg [DEPTH];
    logic [AW-1:0]   wrPtrReg, wrPtrNext;
    logic [AW-1:0]   rdPtrReg, rdPtrNext;
    logic [AW:0]     countReg, countNext;
    logic            full;
    logic            popEff;

    assign full   = (countReg == (AW+1)'(DEPTH));
    assign empty  = (countReg == '0);
    assign popEff = pop && !empty;
    assign rdData = empty ? '0 : memReg[rdPtrReg];

    always_comb begin
        wrPtrNext = wrPtrReg;
        rdPtrNext = rdPtrReg;
        countNext = countReg;
        if (push) begin
            wrPtrNext = wrPtrReg + 1'b1;
        end
        // When full, a lone push drops the oldest entry, so the read pointer moves too.
        if (popEff || (push && full)) begin
            rdPtrNext = rdPtrReg + 1'b1;
        end
        if (push && !popEff && !full) begin
            countNext = countReg + 1'b1;
        end else if (popEff && !push) begin
            countNext = countReg - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            wrPtrReg <= wrPtrNext;
            rdPtrReg <= rdPtrNext;
            countReg <= countNext;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            memReg[wrPtrReg] <= pushData;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and instruction fetch stage: BOOT -> FETCH <-> EXEC with stall, redirect
// and fetch timeout. Optional branch trace buffer enabled by defining BRANCH_TRACE_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int          TIMEOUT      = 16,
    parameter int          TRACE_DEPTH  = 8
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        PCSrc,
    input  logic [31:0] Result,
    input  logic        Stall,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemRData,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus8,
    output logic        FetchErr,
    input  logic        TrcRdEn,
    output logic [63:0] TrcData,
    output logic        TrcEmpty
);

    localparam int            CW          = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

    seqState_t     stateReg, stateNext;
    logic [31:0]   pcReg, pcNext;
    logic [31:0]   instrReg, instrNext;
    logic          reqReg, reqNext;
    logic          validReg, validNext;
    logic          errReg, errNext;
    logic [CW-1:0] waitReg, waitNext;
    logic          takeRedirect;
    logic [31:0]   redirectTgt;

    assign redirectTgt = alignWord(Result);

    always_comb begin
        stateNext    = stateReg;
        pcNext       = pcReg;
        instrNext    = instrReg;
        errNext      = errReg;
        waitNext     = waitReg;
        takeRedirect = 1'b0;
        case (stateReg)
            BOOT: begin
                stateNext = FETCH;
                waitNext  = '0;
            end
            FETCH: begin
                if (IMemAck) begin
                    instrNext = IMemRData;
                    stateNext = EXEC;
                end else if (waitReg != TIMEOUT_CNT) begin
                    // Counter saturates at the limit; an ack this cycle pre-empts the error.
                    waitNext = waitReg + 1'b1;
                    if ((waitReg + 1'b1) == TIMEOUT_CNT) begin
                        errNext = 1'b1;
                    end
                end
            end
            EXEC: begin
                if (!Stall) begin
                    takeRedirect = PCSrc;
                    pcNext       = PCSrc ? redirectTgt : pcReg + PC_STEP;
                    stateNext    = FETCH;
                    waitNext     = '0;
                end
            end
            default: begin
                stateNext = BOOT;
            end
        endcase
        reqNext   = (stateNext == FETCH);
        validNext = (stateNext == EXEC);
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            stateReg <= BOOT;
            pcReg    <= RESET_VECTOR;
            instrReg <= '0;
            reqReg   <= 1'b0;
            validReg <= 1'b0;
            errReg   <= 1'b0;
            waitReg  <= '0;
        end else begin
            stateReg <= stateNext;
            pcReg    <= pcNext;
            instrReg <= instrNext;
            reqReg   <= reqNext;
            validReg <= validNext;
            errReg   <= errNext;
            waitReg  <= waitNext;
        end
    end

    assign IMemReq    = reqReg;
    assign IMemAddr   = pcReg;
    assign Instr      = instrReg;
    assign InstrValid = validReg;
    assign PC         = pcReg;
    assign PCPlus8    = pcReg + 32'd8;
    assign FetchErr   = errReg;

`ifdef BRANCH_TRACE_EN
    trcEntry_t trcPushData;
    trcEntry_t trcRdData;

    assign trcPushData.src = pcReg;
    assign trcPushData.tgt = redirectTgt;

    branch_trace_fifo #(
        .DEPTH (TRACE_DEPTH)
    ) traceFifo (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .push     (takeRedirect),
        .pushData (trcPushData),
        .pop      (TrcRdEn),
        .rdData   (trcRdData),
        .empty    (TrcEmpty)
    );

    assign TrcData = trcRdData;
`else
    logic unusedTrc;
    assign unusedTrc = ^{TrcRdEn, takeRedirect};
    assign TrcData   = '0;
    assign TrcEmpty  = 1'b1;
`endif

endmodule
